// File: rtl/tx_frame_pkg.sv
// tx_frame_pkg: shared word type, packer states and the abort keep code.
// Contents:
//   pack_word_t    - one FIFO entry: packed data, byte enables, end-of-frame flag
//   packer_state_e - packer states SYNC/IDLE/ACCUM/DROP
//   KEEP_ABORT     - keep value that, with last=1, marks an aborted frame
package tx_frame_pkg;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } pack_word_t;
  typedef enum logic [1:0] {SYNC, IDLE, ACCUM, DROP} packer_state_e;
  localparam logic [3:0] KEEP_ABORT = 4'h0;
endpackage

// File: rtl/tx_frame_packer_if.sv
// tx_frame_packer_if: valid/ready word stream from the packer to its consumer.
// Signals:
//   m_data  - packed word, byte 0 in [7:0]
//   m_keep  - contiguous byte enables from bit 0 (4'h0 with m_last = abort)
//   m_last  - final word of a frame
//   m_valid - word available
//   m_ready - consumer accepts the word when m_valid & m_ready
interface tx_frame_packer_if;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;
  modport master(output m_data, m_keep, m_last, m_valid, input m_ready);
  modport slave(input m_data, m_keep, m_last, m_valid, output m_ready);
endinterface

// File: rtl/frame_word_fifo.sv
// frame_word_fifo: synchronous first-word-fall-through FIFO of pack_word_t.
// Ports:
//   clk, rst_n - clock, synchronous active-low reset (flushes contents)
//   push_i     - write wdata_i (ignored when full)
//   pop_i      - drop the head word (ignored when empty)
//   rdata_o    - head word, all zero while empty
//   full_o, empty_o, free_cnt_o - occupancy status before the next edge
module frame_word_fifo import tx_frame_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  pack_word_t               wdata_i,
  output pack_word_t               rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   free_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  pack_word_t    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign empty_o    = cnt_q == '0;
  assign full_o     = cnt_q == (AW+1)'(DEPTH);
  assign free_cnt_o = (AW+1)'(DEPTH) - cnt_q;
  assign rdata_o    = empty_o ? '0 : mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) mem_q[wr_q] <= wdata_i;
      wr_q  <= wr_q + AW'(do_push);
      rd_q  <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/tx_frame_packer.sv
// tx_frame_packer: packs a tx_en-delimited byte stream into little-endian 32-bit words.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   txd_i        - input byte
//   tx_en_i      - byte valid; a frame is a maximal run of tx_en_i=1
//   m            - word stream master (data/keep/last/valid out, ready in)
//   frame_cnt_o  - good frames completed, saturating
//   ovf_cnt_o    - frames aborted for lack of FIFO room, saturating
module tx_frame_packer import tx_frame_pkg::*; #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               txd_i,
  input  logic                     tx_en_i,
  tx_frame_packer_if.master        m,
  output logic [15:0]              frame_cnt_o,
  output logic [15:0]              ovf_cnt_o
);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  packer_state_e state_q, state_d;
  logic [31:0]   acc_q, acc_d;
  logic [2:0]    idx_q, idx_d;
  logic [15:0]   frame_cnt_q, ovf_cnt_q;
  logic          push, frame_inc, ovf_inc, full, empty, room_mid, room_last;
  logic [3:0]    keep_w;
  logic [FW-1:0] free;
  pack_word_t    push_word, head;
  // A mid-frame word must leave one slot free so the frame can always be terminated.
  assign room_mid  = free >= FW'(2);
  assign room_last = !full;
  assign keep_w    = 4'((5'd1 << idx_q) - 5'd1);
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    push      = 1'b0;
    push_word = '0;
    frame_inc = 1'b0;
    ovf_inc   = 1'b0;
    case (state_q)
      SYNC: state_d = tx_en_i ? SYNC : IDLE;
      IDLE: if (tx_en_i) begin
        acc_d   = {24'h0, txd_i};
        idx_d   = 3'd1;
        state_d = ACCUM;
      end
      ACCUM: if (!tx_en_i) begin
        // A terminator refused on a full FIFO loses the whole frame, so count it as overflow.
        push      = room_last;
        push_word = '{acc_q, keep_w, 1'b1};
        frame_inc = room_last;
        ovf_inc   = !room_last;
        state_d   = IDLE;
      end else if (idx_q != 3'd4) begin
        acc_d[8*idx_q[1:0] +: 8] = txd_i;
        idx_d = idx_q + 3'd1;
      end else if (room_mid) begin
        push      = 1'b1;
        push_word = '{acc_q, 4'hF, 1'b0};
        acc_d     = {24'h0, txd_i};
        idx_d     = 3'd1;
      end else begin
        acc_d   = '0;
        idx_d   = '0;
        state_d = DROP;
      end
      DROP: if (!tx_en_i) begin
        push      = room_last;
        push_word = '{32'h0, KEEP_ABORT, 1'b1};
        ovf_inc   = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = SYNC;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SYNC;
      acc_q       <= '0;
      idx_q       <= '0;
      frame_cnt_q <= '0;
      ovf_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_q + 16'(frame_inc && frame_cnt_q != 16'hFFFF);
      ovf_cnt_q   <= ovf_cnt_q + 16'(ovf_inc && ovf_cnt_q != 16'hFFFF);
    end
  end
  frame_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .pop_i      (m.m_ready),
    .wdata_i    (push_word),
    .rdata_o    (head),
    .full_o     (full),
    .empty_o    (empty),
    .free_cnt_o (free)
  );
  assign m.m_valid   = !empty;
  assign m.m_data    = head.data;
  assign m.m_keep    = head.keep;
  assign m.m_last    = head.last;
  assign frame_cnt_o = frame_cnt_q;
  assign ovf_cnt_o   = ovf_cnt_q;
endmodule
